// File: rtl/test_run_controller_pkg.sv
// Shared types for the test run controller: sequencing states and verdict
// resolution when several exit conditions land on the same RUN edge.
package test_run_controller_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RESET,
        RUN,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        V_NONE,
        V_PASS,
        V_FAIL,
        V_TIMEOUT
    } verdict_t;

    // Higher rank wins when exit conditions coincide.
    localparam int unsigned PRIO_TIMEOUT  = 1;
    localparam int unsigned PRIO_ALL_DONE = 2;
    localparam int unsigned PRIO_ERROR    = 3;

    function automatic verdict_t resolve_verdict(input logic err,
                                                 input logic all_done,
                                                 input logic timeout);
        verdict_t    v;
        int unsigned rank;
        v    = V_NONE;
        rank = 0;
        if (timeout && (PRIO_TIMEOUT > rank)) begin
            v    = V_TIMEOUT;
            rank = PRIO_TIMEOUT;
        end
        if (all_done && (PRIO_ALL_DONE > rank)) begin
            v    = V_PASS;
            rank = PRIO_ALL_DONE;
        end
        if (err && (PRIO_ERROR > rank)) begin
            v    = V_FAIL;
        end
        return v;
    endfunction

endpackage

// File: rtl/test_run_controller_watchdog_counter.sv
// Clear/enable up-counter that saturates at p_terminal; 'last' flags that the
// next enabled increment lands on p_terminal.
module watchdog_counter #(
    parameter int unsigned p_width    = 32,
    parameter int unsigned p_terminal = 10000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               enable,
    output logic [p_width-1:0] count,
    output logic               last
);

    assign last = (count == p_width'(p_terminal - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != p_width'(p_terminal))) begin
            count <= count + p_width'(1);
        end
    end

endmodule

// File: rtl/test_run_controller.sv
// Sequences a DUT through reset and a watchdog-bounded run, collecting client
// done/error flags into a single registered pass/fail/timeout verdict.
module test_run_controller
    import test_run_controller_pkg::*;
#(
    parameter int unsigned p_num_clients    = 2,
    parameter int unsigned p_timeout_period = 10000,
    parameter int unsigned p_rst_cycles_w   = 8,
    parameter int unsigned p_cycle_cnt_w    = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [p_rst_cycles_w-1:0] rst_cycles,
    input  logic [p_num_clients-1:0]  client_done,
    input  logic [p_num_clients-1:0]  client_err,
    output logic                      dut_reset,
    output logic                      running,
    output logic [p_cycle_cnt_w-1:0]  cycles,
    output logic [p_num_clients-1:0]  done_mask,
    output logic                      timeout_occurred,
    output logic                      finished,
    output logic                      pass,
    output logic                      fail
);

    state_t                    state, state_d;
    logic [p_rst_cycles_w-1:0] rst_cnt, rst_cnt_d, rst_load;
    logic [p_num_clients-1:0]  done_mask_d;
    logic                      err_q, err_d, err_any, all_done;
    logic                      timeout_d, pass_d, fail_d;
    logic                      wd_clear, wd_enable, wd_last;
    verdict_t                  verdict;

    assign rst_load = (rst_cycles == '0) ? p_rst_cycles_w'(1) : rst_cycles;
    assign all_done = &(done_mask | client_done);
    assign err_any  = err_q | (|client_err);
    assign verdict  = resolve_verdict(err_any, all_done, wd_last);

    watchdog_counter #(
        .p_width    (p_cycle_cnt_w),
        .p_terminal (p_timeout_period)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (wd_clear),
        .enable (wd_enable),
        .count  (cycles),
        .last   (wd_last)
    );

    always_comb begin
        state_d     = state;
        rst_cnt_d   = rst_cnt;
        done_mask_d = done_mask;
        err_d       = err_q;
        timeout_d   = timeout_occurred;
        pass_d      = pass;
        fail_d      = fail;
        wd_clear    = 1'b0;
        wd_enable   = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    rst_cnt_d = rst_load;
                    state_d   = RESET;
                end
            end
            RESET: begin
                if (rst_cnt <= p_rst_cycles_w'(1)) begin
                    state_d     = RUN;
                    wd_clear    = 1'b1;
                    done_mask_d = '0;
                    err_d       = 1'b0;
                end else begin
                    rst_cnt_d = rst_cnt - p_rst_cycles_w'(1);
                end
            end
            RUN: begin
                wd_enable   = 1'b1;
                done_mask_d = done_mask | client_done;
                err_d       = err_any;
                case (verdict)
                    V_PASS: begin
                        state_d = DONE;
                        pass_d  = 1'b1;
                    end
                    V_FAIL: begin
                        state_d = DONE;
                        fail_d  = 1'b1;
                    end
                    V_TIMEOUT: begin
                        state_d   = DONE;
                        fail_d    = 1'b1;
                        timeout_d = 1'b1;
                    end
                    default: ;
                endcase
            end
            DONE: begin
                if (start) begin
                    state_d     = RESET;
                    rst_cnt_d   = rst_load;
                    pass_d      = 1'b0;
                    fail_d      = 1'b0;
                    timeout_d   = 1'b0;
                    done_mask_d = '0;
                    wd_clear    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they change on the same edge as it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            rst_cnt          <= '0;
            done_mask        <= '0;
            err_q            <= 1'b0;
            timeout_occurred <= 1'b0;
            pass             <= 1'b0;
            fail             <= 1'b0;
            dut_reset        <= 1'b1;
            running          <= 1'b0;
            finished         <= 1'b0;
        end else begin
            state            <= state_d;
            rst_cnt          <= rst_cnt_d;
            done_mask        <= done_mask_d;
            err_q            <= err_d;
            timeout_occurred <= timeout_d;
            pass             <= pass_d;
            fail             <= fail_d;
            dut_reset        <= (state_d == IDLE) || (state_d == RESET);
            running          <= (state_d == RUN);
            finished         <= (state_d == DONE);
        end
    end

endmodule

// File: tb/tb_test_run_controller.sv
// Directed and randomized runs of test_run_controller against a run-level
// reference model that derives the exit cycle and verdict from prefix ORs.
module tb_test_run_controller;

    localparam int NC = 2;
    localparam int T  = 20;
    localparam int RW = 8;
    localparam int CW = 32;

    logic          clk;
    logic          reset;
    logic          start;
    logic [RW-1:0] rst_cycles;
    logic [NC-1:0] client_done;
    logic [NC-1:0] client_err;
    logic          dut_reset;
    logic          running;
    logic [CW-1:0] cycles;
    logic [NC-1:0] done_mask;
    logic          timeout_occurred;
    logic          finished;
    logic          pass;
    logic          fail;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [NC-1:0] stim_done [1:T];
    logic [NC-1:0] stim_err  [1:T];

    test_run_controller #(
        .p_num_clients    (NC),
        .p_timeout_period (T),
        .p_rst_cycles_w   (RW),
        .p_cycle_cnt_w    (CW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .rst_cycles       (rst_cycles),
        .client_done      (client_done),
        .client_err       (client_err),
        .dut_reset        (dut_reset),
        .running          (running),
        .cycles           (cycles),
        .done_mask        (done_mask),
        .timeout_occurred (timeout_occurred),
        .finished         (finished),
        .pass             (pass),
        .fail             (fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input string phase, input logic dr, input logic run,
                               input logic [CW-1:0] cyc, input logic [NC-1:0] mask,
                               input logic to, input logic fin, input logic ps,
                               input logic fl);
        chk({phase, ".dut_reset"},        64'(dut_reset),        64'(dr));
        chk({phase, ".running"},          64'(running),          64'(run));
        chk({phase, ".cycles"},           64'(cycles),           64'(cyc));
        chk({phase, ".done_mask"},        64'(done_mask),        64'(mask));
        chk({phase, ".timeout_occurred"}, 64'(timeout_occurred), 64'(to));
        chk({phase, ".finished"},         64'(finished),         64'(fin));
        chk({phase, ".pass"},             64'(pass),             64'(ps));
        chk({phase, ".fail"},             64'(fail),             64'(fl));
    endtask

    task automatic clear_stim();
        for (int m = 1; m <= T; m++) begin
            stim_done[m] = '0;
            stim_err[m]  = '0;
        end
    endtask

    task automatic random_stim();
        for (int m = 1; m <= T; m++) begin
            for (int b = 0; b < NC; b++) begin
                stim_done[m][b] = ($urandom_range(0, 9) == 0);
                stim_err[m][b]  = ($urandom_range(0, 39) == 0);
            end
        end
    endtask

    // Starts a run at the next edge (from IDLE or DONE) and checks every cycle.
    // abort_at > 0 returns right after the check following that many RUN edges.
    task automatic run_and_check(input int r, input int abort_at);
        int            reff;
        int            n;
        logic [NC-1:0] acc;
        logic          eacc;
        logic          exp_pass;
        logic          exp_fail;
        logic          exp_to;
        logic [NC-1:0] mask_after [0:T];

        reff          = (r == 0) ? 1 : r;
        acc           = '0;
        eacc          = 1'b0;
        n             = 0;
        exp_pass      = 1'b0;
        exp_fail      = 1'b0;
        exp_to        = 1'b0;
        mask_after[0] = '0;
        for (int m = 1; m <= T && n == 0; m++) begin
            acc           = acc | stim_done[m];
            eacc          = eacc | (|stim_err[m]);
            mask_after[m] = acc;
            if (eacc) begin
                n        = m;
                exp_fail = 1'b1;
            end else if (&acc) begin
                n        = m;
                exp_pass = 1'b1;
            end else if (m == T) begin
                n        = m;
                exp_fail = 1'b1;
                exp_to   = 1'b1;
            end
        end

        start       = 1'b1;
        rst_cycles  = RW'(r);
        client_done = NC'($urandom);
        client_err  = NC'($urandom);
        for (int t = 0; t <= reff + n; t++) begin
            @(negedge clk);
            if (t < reff)
                chk_outputs("reset_phase", 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
            else if (t < reff + n)
                chk_outputs("run_phase", 1'b0, 1'b1, CW'(t - reff), mask_after[t - reff],
                            1'b0, 1'b0, 1'b0, 1'b0);
            else
                chk_outputs("verdict", 1'b0, 1'b0, CW'(n), mask_after[n],
                            exp_to, 1'b1, exp_pass, exp_fail);
            if (abort_at != 0 && t == reff + abort_at) return;
            if (t + 1 > reff && t + 1 <= reff + n) begin
                client_done = stim_done[t + 1 - reff];
                client_err  = stim_err[t + 1 - reff];
                start       = 1'($urandom_range(0, 1));
            end else if (t + 1 <= reff) begin
                client_done = NC'($urandom);
                client_err  = NC'($urandom);
                start       = 1'($urandom_range(0, 1));
            end else begin
                client_done = NC'($urandom);
                client_err  = NC'($urandom);
                start       = 1'b0;
            end
        end
        for (int h = 0; h < 3; h++) begin
            @(negedge clk);
            chk_outputs("done_hold", 1'b0, 1'b0, CW'(n), mask_after[n],
                        exp_to, 1'b1, exp_pass, exp_fail);
            client_done = NC'($urandom);
            client_err  = NC'($urandom);
        end
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        rst_cycles  = '0;
        client_done = '0;
        client_err  = '0;
        repeat (3) @(negedge clk);
        chk_outputs("in_reset", 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk_outputs("idle", 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Two clients finishing at RUN cycles 5 and 9.
        clear_stim();
        stim_done[5] = 2'b01;
        stim_done[9] = 2'b10;
        run_and_check(3, 0);

        // Nothing finishes: watchdog expires.
        clear_stim();
        run_and_check(5, 0);

        // Error together with the final done.
        clear_stim();
        stim_done[4] = 2'b01;
        stim_done[6] = 2'b10;
        stim_err[6]  = 2'b10;
        run_and_check(2, 0);

        // Final done on the timeout edge.
        clear_stim();
        stim_done[3]  = 2'b01;
        stim_done[T]  = 2'b10;
        run_and_check(1, 0);

        // Zero reset length, error on the first RUN edge.
        clear_stim();
        stim_err[1] = 2'b01;
        run_and_check(0, 0);

        for (int i = 0; i < 12; i++) begin
            random_stim();
            run_and_check(int'($urandom_range(0, 6)), 0);
        end

        // Synchronous reset in the middle of a run.
        clear_stim();
        run_and_check(2, 7);
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        chk_outputs("mid_run_reset", 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk_outputs("idle_after_reset", 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

        random_stim();
        run_and_check(int'($urandom_range(0, 4)), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/test_run_controller.md
# test_run_controller

Synthesizable run controller that sequences a test harness around a DUT. It holds the DUT in reset for a programmable number of cycles, then runs it while counting cycles against a watchdog. It collects sticky done/error flags from N test clients (sources/sinks) and reports a single pass/fail/timeout verdict. It sits between the bench's clock/reset utilities and the DUT plus its test clients, replacing ad-hoc timeout logic with cycle-accurate RTL.

## Interface
- p_num_clients, 2, number of test clients reporting done/error (≥1)
- p_timeout_period, 10000, RUN-cycle budget before timeout
- p_rst_cycles_w, 8, width of the reset-length input
- p_cycle_cnt_w, 32, cycle counter width; must hold p_timeout_period
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- start  input  1  begin a run; sampled in IDLE or DONE only
- rst_cycles  input  p_rst_cycles_w  DUT reset length in cycles; sampled with start; 0 treated as 1
- client_done  input  p_num_clients  per-client done; level or pulse
- client_err  input  p_num_clients  per-client error; level or pulse
- dut_reset  output  1  reset driven to DUT and clients
- running  output  1  high in RUN
- cycles  output  p_cycle_cnt_w  RUN cycles elapsed
- done_mask  output  p_num_clients  sticky per-client done
- timeout_occurred  output  1  sticky, watchdog expired
- finished  output  1  high in DONE
- pass  output  1  finished, no error, no timeout
- fail  output  1  finished with error or timeout

## Operation
- One clock. Reset is synchronous and active-high. All outputs are registered.
- Reset values: state IDLE, dut_reset=1, running=0, cycles=0, done_mask=0, timeout_occurred=0, finished=0, pass=0, fail=0.
- States and transitions:
  - IDLE: dut_reset=1. On start, load the reset counter with max(rst_cycles,1) and go to RESET.
  - RESET: dut_reset=1. Decrement the counter each cycle. At the edge where it reaches its last cycle, go to RUN, clear cycles, done_mask and the error flag.
  - RUN: dut_reset=0, running=1. Each edge: done_mask |= client_done, err |= |client_err, cycles += 1. Exit to DONE when (a) any error, (b) done_mask including this edge's inputs is all ones, or (c) cycles == p_timeout_period.
  - DONE: finished=1 and the verdict holds. start → RESET: clear verdict, done_mask, cycles, timeout_occurred, and load the new rst_cycles. dut_reset stays 0 in DONE until start.
- Verdict priority when exit conditions coincide on the same edge:
  - error → fail.
  - Else all done → pass. All done on the timeout edge counts as pass.
  - Else timeout → fail, timeout_occurred=1.
- client_done and client_err are ignored outside RUN.
- start is ignored in RESET and RUN.
- cycles holds in DONE and IDLE. It never wraps, because it stops at p_timeout_period.
- reset asserted in any state returns everything to the reset values on the next edge, including mid-RUN and mid-RESET.

## Timing
- start at edge k with rst_cycles=R gives:
  - dut_reset=1 for cycles k+1…k+R.
  - dut_reset=0 and running=1 from edge k+R onward.
- The exit condition sampled at edge e gives finished/pass/fail valid after edge e, with running=0 in the same cycle. Verdict latency is 1 cycle.
- cycles reads n after the n-th RUN edge. The timeout verdict appears after exactly p_timeout_period RUN edges.

## Structure
- Package test_run_controller_pkg holds:
  - State enum {IDLE, RESET, RUN, DONE}.
  - Verdict-priority localparams.
- Sub-module watchdog_counter: a clear/enable/saturating counter with a terminal-match output. It is used for cycles and timeout. The reset down-counter stays inline.

## Test plan
- Reset, then start with rst_cycles=3: dut_reset high exactly 3 cycles after start, then running=1, cycles counts 1,2,3….
- p_num_clients=2: client_done[0] pulses at RUN cycle 5, client_done[1] at cycle 9 → done_mask=01 then 11; finished and pass high after the edge at cycle 9.
- p_timeout_period=20, no done → fail=1, timeout_occurred=1, cycles=20, pass=0.
- Coincidences:
  - client_err[1] and the final client_done on the same edge → fail=1, pass=0.
  - Final done on the timeout edge → pass=1, timeout_occurred=0.
- rst_cycles=0 → exactly 1 dut_reset cycle. start during RUN is ignored. start in DONE restarts with a cleared verdict.
- reset asserted mid-RUN at cycle 7 → all outputs return to reset values next edge, dut_reset=1, state IDLE.
